// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and the {pc, instr} entry passed from fetch to decode
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_rv32i_if.sv
// ifetch_rv32i_if: imem request/response channel plus the decode-side output channel
interface ifetch_rv32i_if;
  logic req_valid;
  logic req_ready;
  logic [rv32i_pkg::XLEN-1:0] req_addr;
  logic rsp_valid;
  logic [rv32i_pkg::XLEN-1:0] rsp_data;
  logic out_valid;
  logic out_ready;
  logic [rv32i_pkg::XLEN-1:0] out_pc;
  logic [rv32i_pkg::XLEN-1:0] out_instr;
  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_instr,
    input  req_ready, rsp_valid, rsp_data, out_ready
  );
  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_instr,
    output req_ready, rsp_valid, rsp_data, out_ready
  );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: sync FIFO with flush, simultaneous push/pop and count; head read from registered storage
module ifetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic push_i,
  input  fetch_entry_t push_data_i,
  input  logic pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  assign do_pop = pop_i && cnt_q != '0;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/ifetch_rv32i.sv
// ifetch_rv32i: RV32I fetch unit issuing in-order imem requests under a credit limit,
// pairing responses with PCs into a decode FIFO and flushing stale fetches on redirect
module ifetch_rv32i
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic misalign_err,
  ifetch_rv32i_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_W = CW'(MAX_OUTSTANDING);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, count;
  logic [CW:0] credit;
  logic misalign_q, misalign_d, accept, drop, push, pop;
  fetch_entry_t head, push_data;
  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  // Every non-stale request reserves a FIFO slot, so responses never need backpressure
  assign credit = {1'b0, count} + {1'b0, inflight_q} - {1'b0, discard_q};
  assign bus.req_valid = !reset && !redirect_valid && inflight_q < MAX_W && credit < DEPTH_W;
  assign bus.req_addr = fetch_pc_q;
  assign accept = bus.req_valid && bus.req_ready;
  assign drop = discard_q != '0;
  assign push = bus.rsp_valid && !drop && !redirect_valid;
  assign pop = bus.out_valid && bus.out_ready;
  assign push_data = {rsp_pc_q, bus.rsp_data};
  always_comb begin
    fetch_pc_d = redirect_valid ? target : accept ? fetch_pc_q + STEP : fetch_pc_q;
    rsp_pc_d = redirect_valid ? target : push ? rsp_pc_q + STEP : rsp_pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(bus.rsp_valid);
    discard_d = redirect_valid ? inflight_q - CW'(bus.rsp_valid)
              : (bus.rsp_valid && drop) ? discard_q - 1'b1 : discard_q;
    misalign_d = misalign_q || (redirect_valid && redirect_pc[1:0] != 2'b00);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q <= discard_d;
      misalign_q <= misalign_d;
    end
  end
  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(reset),
    .flush_i(redirect_valid),
    .push_i(push),
    .push_data_i(push_data),
    .pop_i(pop),
    .head_o(head),
    .count_o(count)
  );
  assign bus.out_valid = count != '0;
  assign bus.out_pc = head.pc;
  assign bus.out_instr = head.instr;
  assign misalign_err = misalign_q;
endmodule

// File: tb/tb_ifetch_rv32i.sv
// tb_ifetch_rv32i: cycle-level imem model, reference credit/discard model and output scoreboard
module tb_ifetch_rv32i;
  import rv32i_pkg::*;
  localparam int D = 4;
  localparam int MO = 2;
  typedef struct { logic [31:0] addr; int due; } imreq_t;
  typedef struct { int lat; logic [31:0] rpc; logic mis; logic [31:0] pc0, pc1, pc2; } vec_t;

  logic clk = 1'b0;
  logic reset, redirect_valid, misalign_err;
  logic [31:0] redirect_pc;
  ifetch_rv32i_if bus();
  ifetch_rv32i dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .misalign_err(misalign_err),
    .bus(bus)
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, lat = 1, first_acc = -1, first_pop = -1;
  logic rst_v, rdv, rq_rdy, o_rdy, rsp_en;
  logic [31:0] rdpc;
  imreq_t imq[$];
  fetch_entry_t sb[$];
  logic [31:0] pops[$];
  int b_infl, b_disc, b_cnt;
  logic b_mis;
  logic [31:0] b_fpc, b_rpc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_pop(input string name, input int i, input logic [31:0] exp);
    if (i >= pops.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d outputs seen, expected pc %h at index %0d", name, pops.size(), exp, i);
    end else chk32(name, pops[i], exp);
  endtask

  task automatic bound(input string name, input logic ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: setup state not reached within cycle budget", name);
    end
  endtask

  // One clock: drive inputs, sample outputs mid-cycle, advance the reference model
  task automatic tick();
    logic rsp, exp_rv, acc, pop, live;
    logic [31:0] rdata;
    fetch_entry_t e;
    reset = rst_v;
    redirect_valid = rdv;
    redirect_pc = rdpc;
    bus.req_ready = rq_rdy;
    bus.out_ready = o_rdy;
    rsp = 1'b0;
    rdata = '0;
    if (rsp_en && imq.size() > 0 && imq[0].due <= cyc) begin
      rsp = 1'b1;
      rdata = instr_of(imq[0].addr);
      void'(imq.pop_front());
    end
    bus.rsp_valid = rsp;
    bus.rsp_data = rdata;
    #2;
    if (rst_v) begin
      chk1("reset_req_valid", bus.req_valid, 1'b0);
      b_infl = 0; b_disc = 0; b_cnt = 0; b_mis = 1'b0;
      b_fpc = RESET_PC_DEFAULT; b_rpc = RESET_PC_DEFAULT;
      sb.delete();
      imq.delete();
    end else begin
      exp_rv = !rdv && b_infl < MO && (b_cnt + b_infl - b_disc) < D;
      chk1("req_valid", bus.req_valid, exp_rv);
      chk1("out_valid", bus.out_valid, b_cnt != 0);
      chk1("misalign_err", misalign_err, b_mis);
      assert (!(rsp && b_infl == 0)) else begin
        errors++;
        $display("FAIL rsp_without_inflight: rsp_valid=1 with 0 requests in flight (cycle %0d)", cyc);
      end
      acc = bus.req_valid && rq_rdy;
      if (acc) begin
        chk32("req_addr", bus.req_addr, b_fpc);
        imq.push_back('{addr: bus.req_addr, due: cyc + lat});
        if (first_acc < 0) first_acc = cyc;
      end
      pop = bus.out_valid && o_rdy && !rdv;
      if (pop) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h, expected no output", bus.out_pc);
        end else begin
          e = sb.pop_front();
          chk32("out_pc", bus.out_pc, e.pc);
          chk32("out_instr", bus.out_instr, e.instr);
        end
        pops.push_back(bus.out_pc);
        if (first_pop < 0) first_pop = cyc;
      end
      live = rsp && b_disc == 0 && !rdv;
      if (live) sb.push_back({b_rpc, instr_of(b_rpc)});
      if (rdv) begin
        b_cnt = 0;
        b_infl = b_infl - int'(rsp);
        b_disc = b_infl;
        b_fpc = {rdpc[31:2], 2'b00};
        b_rpc = b_fpc;
        b_mis = b_mis || rdpc[1:0] != 2'b00;
        sb.delete();
      end else begin
        if (acc) b_fpc = b_fpc + 32'd4;
        if (live) b_rpc = b_rpc + 32'd4;
        if (rsp && b_disc > 0) b_disc--;
        b_infl = b_infl + int'(acc) - int'(rsp);
        b_cnt = b_cnt + int'(live) - int'(pop);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t vt[5];
    int nstale;
    vt[0] = '{1, 32'h0000_0040, 1'b0, 32'h0000_0040, 32'h0000_0044, 32'h0000_0048};
    vt[1] = '{2, 32'h0000_0102, 1'b1, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    vt[2] = '{1, 32'h0000_0200, 1'b1, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
    vt[3] = '{3, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[4] = '{1, 32'h0000_0013, 1'b1, 32'h0000_0010, 32'h0000_0014, 32'h0000_0018};
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    bus.req_ready = 1'b0; bus.out_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
    rst_v = 1'b1; rdv = 1'b0; rdpc = '0; rq_rdy = 1'b1; o_rdy = 1'b1; rsp_en = 1'b1;
    @(posedge clk);
    #1;

    // Streaming fetch from reset
    repeat (2) tick();
    rst_v = 1'b0;
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk1("reset_misalign", misalign_err, 1'b0);
    chk32("reset_req_addr", bus.req_addr, RESET_PC_DEFAULT);
    pops.delete(); first_acc = -1; first_pop = -1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) chk_pop("stream_pc", i, 32'(i * 4));
    chk32("first_out_latency", 32'(first_pop - first_acc), 32'd2);

    // Backpressure fills the buffer, then drains in order
    rst_v = 1'b1; repeat (2) tick(); rst_v = 1'b0; o_rdy = 1'b0;
    repeat (10) tick();
    chk1("full_out_valid", bus.out_valid, 1'b1);
    chk1("full_req_valid", bus.req_valid, 1'b0);
    o_rdy = 1'b1; pops.delete();
    repeat (10) tick();
    for (int i = 0; i < 5; i++) chk_pop("drain_pc", i, 32'(i * 4));

    // Redirect with 0x20/0x24 in flight, coincident with the 0x20 response
    rst_v = 1'b1; repeat (2) tick(); rst_v = 1'b0;
    for (int k = 0; k < 40 && !(b_infl == 2 && imq.size() > 0 && imq[0].addr == 32'h20); k++) begin
      rsp_en = !(imq.size() > 0 && imq[0].addr == 32'h20);
      tick();
    end
    bound("stale_setup", b_infl == 2 && imq.size() == 2 && imq[0].addr == 32'h20);
    rsp_en = 1'b1; pops.delete();
    rdv = 1'b1; rdpc = 32'h0000_0100; tick(); rdv = 1'b0;
    repeat (10) tick();
    chk_pop("redirect_first_pc", 0, 32'h0000_0100);
    nstale = 0;
    foreach (pops[j]) if (pops[j] == 32'h20 || pops[j] == 32'h24) nstale++;
    chk32("stale_outputs", 32'(nstale), 32'd0);

    // Redirect table: alignment, sticky misalign, wrap-around, varied imem latency
    for (int i = 0; i < 5; i++) begin
      lat = vt[i].lat;
      pops.delete();
      rdv = 1'b1; rdpc = vt[i].rpc; tick(); rdv = 1'b0;
      chk32("redirect_req_addr", bus.req_addr, {vt[i].rpc[31:2], 2'b00});
      repeat (14) tick();
      chk1("misalign_sticky", misalign_err, vt[i].mis);
      chk_pop("vec_pc0", 0, vt[i].pc0);
      chk_pop("vec_pc1", 1, vt[i].pc1);
      chk_pop("vec_pc2", 2, vt[i].pc2);
    end

    // Reset with entries buffered and requests in flight (credit caps the sum at depth)
    lat = 1;
    rst_v = 1'b1; repeat (2) tick(); rst_v = 1'b0; o_rdy = 1'b0;
    for (int k = 0; k < 20 && !(b_cnt == 2 && b_infl == 2); k++) begin
      rsp_en = b_cnt < 2;
      tick();
    end
    bound("reset_setup", b_cnt == 2 && b_infl == 2);
    rsp_en = 1'b1; rst_v = 1'b1;
    tick();
    chk1("reset_flush_out_valid", bus.out_valid, 1'b0);
    chk1("reset_clears_misalign", misalign_err, 1'b0);
    tick();
    rst_v = 1'b0;
    chk32("reset_restart_addr", bus.req_addr, RESET_PC_DEFAULT);
    o_rdy = 1'b1; pops.delete();
    repeat (8) tick();
    chk_pop("after_reset_pc0", 0, 32'h0000_0000);
    chk_pop("after_reset_pc1", 1, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
